isolde_xif_coproc_seq: RTL and testbench



---
 rtl/isolde_xif_coproc_pkg.sv | 29 ++
 rtl/isolde_xif_coproc_alu.sv | 23 ++
 rtl/isolde_xif_coproc_seq.sv | 150 +++++++++++++++
 tb/tb_isolde_xif_coproc_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isolde_xif_coproc_pkg.sv
// Shared constants, buffer entry payload and decoder for the XIF coprocessor.
// Define ISOLDE_XIF_COPROC_MAX_EN to add the signed MAX operation (funct3=010).
package isolde_xif_coproc_pkg;

   localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
   localparam logic [6:0] FUNCT7_ZERO    = 7'b0000000;
   localparam logic [2:0] F3_ADD         = 3'b000;
   localparam logic [2:0] F3_XOR         = 3'b001;
   localparam logic [2:0] F3_MAX         = 3'b010;

   // Payload part of a buffer entry; id and status flags live in their own arrays
   // because the flags are reset while the payload is not.
   typedef struct packed {
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } entry_data_t;

   function automatic logic decode_ok(input logic [31:0] instr);
      logic f3_ok;
      f3_ok = (instr[14:12] == F3_ADD) || (instr[14:12] == F3_XOR);
`ifdef ISOLDE_XIF_COPROC_MAX_EN
      f3_ok = f3_ok || (instr[14:12] == F3_MAX);
`endif
      return (instr[6:0] == OPCODE_CUSTOM0) && (instr[31:25] == FUNCT7_ZERO) && f3_ok;
   endfunction

endpackage

// File: rtl/isolde_xif_coproc_alu.sv
// Combinational datapath: ADD, XOR and (with ISOLDE_XIF_COPROC_MAX_EN) signed MAX.
module isolde_xif_coproc_alu
   import isolde_xif_coproc_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   output logic [31:0] data_o
);

   always_comb begin
      data_o = '0;
      case (funct3_i)
         F3_ADD: data_o = rs1_i + rs2_i;
         F3_XOR: data_o = rs1_i ^ rs2_i;
`ifdef ISOLDE_XIF_COPROC_MAX_EN
         F3_MAX: data_o = ($signed(rs1_i) > $signed(rs2_i)) ? rs1_i : rs2_i;
`endif
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/isolde_xif_coproc_seq.sv
// In-order XIF coprocessor: issue buffer, commit/kill marking, in-order result return.
// Optional signed MAX operation enabled by ISOLDE_XIF_COPROC_MAX_EN.
module isolde_xif_coproc_seq
   import isolde_xif_coproc_pkg::*;
#(
   parameter int X_ID_WIDTH = 4,
   parameter int DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [31:0]           issue_instr_i,
   input  logic [X_ID_WIDTH-1:0] issue_id_i,
   input  logic [1:0][31:0]      issue_rs_i,
   input  logic [1:0]            issue_rs_valid_i,
   output logic                  issue_accept_o,
   output logic                  issue_writeback_o,
   output logic                  issue_dualwrite_o,
   output logic [2:0]            issue_dualread_o,
   output logic                  issue_loadstore_o,
   output logic                  issue_ecswrite_o,
   output logic                  issue_exc_o,
   input  logic                  commit_valid_i,
   input  logic [X_ID_WIDTH-1:0] commit_id_i,
   input  logic                  commit_kill_i,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [X_ID_WIDTH-1:0] result_id_o,
   output logic [31:0]           result_data_o,
   output logic [4:0]            result_rd_o,
   output logic                  result_we_o,
   output logic                  busy_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [DEPTH-1:0]      occ_q, occ_d, cmt_q, cmt_d, kill_q, kill_d;
   entry_data_t           data_q [DEPTH];
   entry_data_t           data_d [DEPTH];
   logic [X_ID_WIDTH-1:0] id_q [DEPTH];
   logic [X_ID_WIDTH-1:0] id_d [DEPTH];

   logic        full, push, pop, drop, same_cmt;
   entry_data_t head_data;
   logic        unused_instr;

   // Handshakes: a transfer happens on a cycle where valid && ready are both high;
   // ready never looks at valid, and valid/payload hold until the transfer.
   assign full          = (count_q == CNT_W'(DEPTH));
   assign issue_ready_o = !full;
   assign issue_accept_o    = decode_ok(issue_instr_i) && (&issue_rs_valid_i);
   assign issue_writeback_o = issue_accept_o;
   assign issue_dualwrite_o = 1'b0;
   assign issue_dualread_o  = 3'b000;
   assign issue_loadstore_o = 1'b0;
   assign issue_ecswrite_o  = 1'b0;
   assign issue_exc_o       = 1'b0;
   assign unused_instr      = ^issue_instr_i[24:15];

   assign push     = issue_valid_i && issue_ready_o && issue_accept_o;
   assign same_cmt = commit_valid_i && (commit_id_i == issue_id_i);

   assign head_data      = data_q[head_q];
   assign result_valid_o = occ_q[head_q] && cmt_q[head_q] && !kill_q[head_q];
   assign drop           = occ_q[head_q] && kill_q[head_q];
   assign pop            = drop || (result_valid_o && result_ready_i);
   assign result_id_o    = id_q[head_q];
   assign result_rd_o    = head_data.rd;
   assign result_we_o    = 1'b1;
   assign busy_o         = (count_q != '0);

   isolde_xif_coproc_alu u_alu (
      .funct3_i (head_data.funct3),
      .rs1_i    (head_data.rs1),
      .rs2_i    (head_data.rs2),
      .data_o   (result_data_o)
   );

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      occ_d   = occ_q;
      cmt_d   = cmt_q;
      kill_d  = kill_q;
      data_d  = data_q;
      id_d    = id_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (commit_valid_i && occ_q[i] && (id_q[i] == commit_id_i)) begin
            cmt_d[i]  = 1'b1;
            kill_d[i] = commit_kill_i;
         end
      end

      if (pop) begin
         occ_d[head_q]  = 1'b0;
         cmt_d[head_q]  = 1'b0;
         kill_d[head_q] = 1'b0;
         head_d         = head_q + 1'b1;
      end

      // A push never lands on the popping head: push needs not-full, pop needs non-empty.
      if (push) begin
         occ_d[tail_q]         = 1'b1;
         cmt_d[tail_q]         = same_cmt;
         kill_d[tail_q]        = same_cmt && commit_kill_i;
         data_d[tail_q].rd     = issue_instr_i[11:7];
         data_d[tail_q].funct3 = issue_instr_i[14:12];
         data_d[tail_q].rs1    = issue_rs_i[0];
         data_d[tail_q].rs2    = issue_rs_i[1];
         id_d[tail_q]          = issue_id_i;
         tail_d                = tail_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= '0;
         cmt_q   <= '0;
         kill_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         cmt_q   <= cmt_d;
         kill_q  <= kill_d;
      end
   end

   always_ff @(posedge clk_i) begin
      data_q <= data_d;
      id_q   <= id_d;
   end

endmodule

// File: tb/tb_isolde_xif_coproc_seq.sv
// Directed bench for isolde_xif_coproc_seq; MAX expectations follow ISOLDE_XIF_COPROC_MAX_EN.
module tb_isolde_xif_coproc_seq;
   import isolde_xif_coproc_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            issue_valid, issue_ready;
   logic [31:0]     issue_instr;
   logic [3:0]      issue_id;
   logic [1:0][31:0] issue_rs;
   logic [1:0]      issue_rs_valid;
   logic            issue_accept, issue_writeback, issue_dualwrite;
   logic [2:0]      issue_dualread;
   logic            issue_loadstore, issue_ecswrite, issue_exc;
   logic            commit_valid, commit_kill;
   logic [3:0]      commit_id;
   logic            result_valid, result_ready;
   logic [3:0]      result_id;
   logic [31:0]     result_data;
   logic [4:0]      result_rd;
   logic            result_we, busy;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic exp_max_acc;

   always #5 clk = ~clk;

   isolde_xif_coproc_seq #(.X_ID_WIDTH(4), .DEPTH(4)) dut (
      .clk_i (clk), .rst_ni (rst_n),
      .issue_valid_i (issue_valid), .issue_ready_o (issue_ready),
      .issue_instr_i (issue_instr), .issue_id_i (issue_id),
      .issue_rs_i (issue_rs), .issue_rs_valid_i (issue_rs_valid),
      .issue_accept_o (issue_accept), .issue_writeback_o (issue_writeback),
      .issue_dualwrite_o (issue_dualwrite), .issue_dualread_o (issue_dualread),
      .issue_loadstore_o (issue_loadstore), .issue_ecswrite_o (issue_ecswrite),
      .issue_exc_o (issue_exc),
      .commit_valid_i (commit_valid), .commit_id_i (commit_id), .commit_kill_i (commit_kill),
      .result_valid_o (result_valid), .result_ready_i (result_ready),
      .result_id_o (result_id), .result_data_o (result_data),
      .result_rd_o (result_rd), .result_we_o (result_we), .busy_o (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] op);
      return {f7, 10'd0, f3, rd, op};
   endfunction

   // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      issue_valid    = 1'b0;
      issue_instr    = '0;
      issue_id       = '0;
      issue_rs       = '0;
      issue_rs_valid = 2'b00;
      commit_valid   = 1'b0;
      commit_id      = '0;
      commit_kill    = 1'b0;
   endtask

   task automatic drive_issue(input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] id,
                              input logic [31:0] rs1, input logic [31:0] rs2);
      issue_valid    = 1'b1;
      issue_instr    = mk_instr(FUNCT7_ZERO, f3, rd, OPCODE_CUSTOM0);
      issue_id       = id;
      issue_rs       = {rs2, rs1};
      issue_rs_valid = 2'b11;
   endtask

   task automatic drive_commit(input logic [3:0] id, input logic kill);
      commit_valid = 1'b1;
      commit_id    = id;
      commit_kill  = kill;
   endtask

   initial begin
`ifdef ISOLDE_XIF_COPROC_MAX_EN
      exp_max_acc = 1'b1;
`else
      exp_max_acc = 1'b0;
`endif
      rst_n = 1'b0;
      result_ready = 1'b0;
      idle();
      #3;
      check("rst_rvalid", 32'(result_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      #10 rst_n = 1'b1;
      #1;
      check("rst_ready", 32'(issue_ready), 32'd1);
      step();

      // ADD with same-cycle commit: result on the next cycle
      drive_issue(F3_ADD, 5'd7, 4'd3, 32'h0000_0005, 32'hFFFF_FFFF);
      drive_commit(4'd3, 1'b0);
      settle();
      check("add_accept", 32'(issue_accept), 32'd1);
      check("add_wb", 32'(issue_writeback), 32'd1);
      check("add_const0", {25'd0, issue_dualwrite, issue_dualread, issue_loadstore,
                           issue_ecswrite, issue_exc}, 32'd0);
      check("add_rv_early", 32'(result_valid), 32'd0);
      step(); idle(); settle();
      check("add_rv", 32'(result_valid), 32'd1);
      check("add_id", 32'(result_id), 32'd3);
      check("add_data", result_data, 32'h0000_0004);
      check("add_rd", 32'(result_rd), 32'd7);
      check("add_we", 32'(result_we), 32'd1);
      check("add_busy", 32'(busy), 32'd1);
      result_ready = 1'b1;
      step(); result_ready = 1'b0; settle();
      check("add_busy_end", 32'(busy), 32'd0);

      // Out-of-order commits, in-order results
      drive_issue(F3_ADD, 5'd1, 4'd1, 32'd1, 32'd2);
      step();
      drive_issue(F3_XOR, 5'd2, 4'd2, 32'h0000_00F0, 32'h0000_000F);
      step(); idle();
      drive_commit(4'd2, 1'b0);
      step(); idle(); settle();
      check("ord_block0", 32'(result_valid), 32'd0);
      step(); settle();
      check("ord_block1", 32'(result_valid), 32'd0);
      drive_commit(4'd1, 1'b0);
      settle();
      check("ord_block2", 32'(result_valid), 32'd0);
      step(); idle(); settle();
      check("ord_rv1", 32'(result_valid), 32'd1);
      check("ord_id1", 32'(result_id), 32'd1);
      check("ord_data1", result_data, 32'd3);
      result_ready = 1'b1;
      step(); settle();
      check("ord_rv2", 32'(result_valid), 32'd1);
      check("ord_id2", 32'(result_id), 32'd2);
      check("ord_data2", result_data, 32'h0000_00FF);
      step(); result_ready = 1'b0; settle();
      check("ord_rv_end", 32'(result_valid), 32'd0);
      check("ord_busy_end", 32'(busy), 32'd0);

      // Killed entry is dropped silently
      drive_issue(F3_XOR, 5'd5, 4'd5, 32'h1234_5678, 32'hFFFF_0000);
      step(); idle(); settle();
      check("kill_busy0", 32'(busy), 32'd1);
      drive_commit(4'd5, 1'b1);
      step(); idle(); settle();
      check("kill_rv", 32'(result_valid), 32'd0);
      check("kill_busy1", 32'(busy), 32'd1);
      step(); settle();
      check("kill_rv2", 32'(result_valid), 32'd0);
      check("kill_busy2", 32'(busy), 32'd0);

      // Fill to DEPTH, back-pressure, no pass-through while full
      for (int i = 0; i < 4; i++) begin
         drive_issue(F3_ADD, 5'(i + 1), 4'(8 + i), 32'(i), 32'd10);
         if (i == 0) drive_commit(4'd8, 1'b0);
         else commit_valid = 1'b0;
         settle();
         check($sformatf("fill_ready%0d", i), 32'(issue_ready), 32'd1);
         step();
      end
      idle(); settle();
      check("full_ready", 32'(issue_ready), 32'd0);
      check("full_rv", 32'(result_valid), 32'd1);
      check("full_id", 32'(result_id), 32'd8);
      check("full_data", result_data, 32'd10);
      result_ready = 1'b1;
      drive_issue(F3_ADD, 5'd12, 4'd12, 32'd100, 32'd100);
      settle();
      check("full_pop_ready", 32'(issue_ready), 32'd0);
      step(); result_ready = 1'b0; idle(); settle();
      check("after_pop_ready", 32'(issue_ready), 32'd1);
      check("after_pop_rv", 32'(result_valid), 32'd0);
      for (int i = 1; i < 4; i++) begin
         drive_commit(4'(8 + i), 1'b0);
         step();
      end
      idle(); result_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         settle();
         check($sformatf("drain_rv%0d", i), 32'(result_valid), 32'd1);
         check($sformatf("drain_id%0d", i), 32'(result_id), 32'(8 + i));
         check($sformatf("drain_data%0d", i), result_data, 32'(10 + i));
         step();
      end
      result_ready = 1'b0; settle();
      check("drain_rv_end", 32'(result_valid), 32'd0);
      check("drain_busy_end", 32'(busy), 32'd0);

      // Rejections
      drive_issue(F3_ADD, 5'd3, 4'd4, 32'd1, 32'd1);
      issue_instr = mk_instr(FUNCT7_ZERO, F3_ADD, 5'd3, 7'b0110011);
      settle();
      check("rej_op_acc", 32'(issue_accept), 32'd0);
      check("rej_op_wb", 32'(issue_writeback), 32'd0);
      step();
      drive_issue(F3_ADD, 5'd3, 4'd4, 32'd1, 32'd1);
      issue_rs_valid = 2'b01;
      settle();
      check("rej_rsv_acc", 32'(issue_accept), 32'd0);
      check("rej_rsv_wb", 32'(issue_writeback), 32'd0);
      step();
      drive_issue(F3_ADD, 5'd3, 4'd4, 32'd1, 32'd1);
      issue_instr = mk_instr(7'b0100000, F3_ADD, 5'd3, OPCODE_CUSTOM0);
      settle();
      check("rej_f7_acc", 32'(issue_accept), 32'd0);
      step();
      drive_issue(3'b011, 5'd3, 4'd4, 32'd1, 32'd1);
      settle();
      check("rej_f3_acc", 32'(issue_accept), 32'd0);
      step(); idle(); settle();
      check("rej_busy", 32'(busy), 32'd0);

      // MAX: signed, only with the feature compiled in
      drive_issue(F3_MAX, 5'd9, 4'd6, 32'h8000_0000, 32'h0000_0001);
      drive_commit(4'd6, 1'b0);
      settle();
      check("max_acc", 32'(issue_accept), 32'(exp_max_acc));
      step(); idle(); settle();
      check("max_rv", 32'(result_valid), 32'(exp_max_acc));
`ifdef ISOLDE_XIF_COPROC_MAX_EN
      check("max_data", result_data, 32'h0000_0001);
`endif
      result_ready = 1'b1;
      step(); result_ready = 1'b0; settle();
      check("max_busy_end", 32'(busy), 32'd0);

      // Reset mid-operation discards everything
      for (int i = 0; i < 3; i++) begin
         drive_issue(F3_ADD, 5'd1, 4'(1 + i), 32'd1, 32'd1);
         drive_commit(4'(1 + i), 1'b0);
         step();
      end
      idle(); settle();
      check("mid_rv", 32'(result_valid), 32'd1);
      check("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_rv", 32'(result_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      #10 rst_n = 1'b1;
      step(); settle();
      check("post_rst_ready", 32'(issue_ready), 32'd1);
      check("post_rst_rv", 32'(result_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
